// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported backing memory between the instruction-fetch port
// and the data-memory port. One requester is granted at a time; each access
// runs IDLE -> BUSY -> RESP and ends with a one-cycle registered acknowledge
// on the granted port only.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   : a 16-bit watchdog ends a BUSY phase after TIMEOUT_CYCLES cycles
//               without mem_ready; the ack is then returned with bus_err=1 and
//               zero read data.
//   undefined : no watchdog; BUSY waits for mem_ready indefinitely and
//               bus_err is constant 0.

module mem_port_arbiter #(
  parameter int unsigned ADDR_BITS      = 64,
  parameter int unsigned DATA_BITS      = 64,
  parameter int unsigned INSTR_BITS     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_BITS-1:0]  if_addr,
  output logic                  if_ack,
  output logic [INSTR_BITS-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_BITS-1:0]  dm_addr,
  input  logic [2:0]            dm_funct3,
  input  logic [DATA_BITS-1:0]  dm_wdata,
  output logic                  dm_ack,
  output logic [DATA_BITS-1:0]  dm_rdata,
  output logic                  bus_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [2:0]            mem_funct3,
  output logic [DATA_BITS-1:0]  mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_BITS-1:0]  mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // last_grant encoding: 0 = fetch port, 1 = data port
  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;

  // Elaboration-time guard on the watchdog range (16-bit counter)
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t                 state_r;
  state_t                 state_next_s;
  logic                   grant_s;
  logic                   grant_dm_s;
  logic                   complete_s;
  logic                   timeout_s;
  logic                   wd_expired_s;
  logic                   last_grant_r;
  logic                   mem_req_r;
  logic                   mem_we_r;
  logic [ADDR_BITS-1:0]   mem_addr_r;
  logic [2:0]             mem_funct3_r;
  logic [DATA_BITS-1:0]   mem_wdata_r;
  logic [DATA_BITS-1:0]   rdata_q_r;
  logic                   if_ack_r;
  logic                   dm_ack_r;
  logic                   bus_err_r;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt_r;

  // Watchdog: cleared on grant, counts each BUSY cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_r <= 16'd0;
    end else if (grant_s) begin
      wd_cnt_r <= 16'd0;
    end else if (state_r == ST_BUSY) begin
      wd_cnt_r <= wd_cnt_r + 16'd1;
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end

  // Expires in the TIMEOUT_CYCLES-th BUSY cycle (count starts at 0)
  assign wd_expired_s = (state_r == ST_BUSY) && (wd_cnt_r == WD_LIMIT);
`else
  assign wd_expired_s = 1'b0;
`endif

  // Next-state, arbitration and completion decode
  always_comb begin
    state_next_s = state_r;
    grant_s      = 1'b0;
    grant_dm_s   = 1'b0;
    complete_s   = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (if_req && dm_req) begin
          // Contention: the port that did not win last time goes first
          grant_s    = 1'b1;
          grant_dm_s = (last_grant_r == GRANT_IF);
        end else if (dm_req) begin
          grant_s    = 1'b1;
          grant_dm_s = 1'b1;
        end else if (if_req) begin
          grant_s    = 1'b1;
          grant_dm_s = 1'b0;
        end else begin
          grant_s    = 1'b0;
          grant_dm_s = 1'b0;
        end
        if (grant_s) begin
          state_next_s = ST_BUSY;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // A real completion in the limit cycle beats the watchdog
        if (mem_ready) begin
          complete_s   = 1'b1;
          state_next_s = ST_RESP;
        end else if (wd_expired_s) begin
          timeout_s    = 1'b1;
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_RESP: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Command latch and grant history, loaded only at grant
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= GRANT_IF;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_BITS{1'b0}};
      mem_funct3_r <= 3'b000;
      mem_wdata_r  <= {DATA_BITS{1'b0}};
    end else if (grant_s) begin
      last_grant_r <= grant_dm_s;
      mem_we_r     <= grant_dm_s & dm_we;
      mem_addr_r   <= grant_dm_s ? dm_addr : if_addr;
      mem_funct3_r <= grant_dm_s ? dm_funct3 : 3'b000;
      mem_wdata_r  <= grant_dm_s ? dm_wdata : {DATA_BITS{1'b0}};
    end
  end

  // Memory request flag: raised on grant, dropped when BUSY ends
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_r <= 1'b0;
    end else if (grant_s) begin
      mem_req_r <= 1'b1;
    end else if (complete_s || timeout_s) begin
      mem_req_r <= 1'b0;
    end
  end

  // Read-data capture; a timed-out access returns zero
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q_r <= {DATA_BITS{1'b0}};
    end else if (complete_s) begin
      rdata_q_r <= mem_rdata;
    end else if (timeout_s) begin
      rdata_q_r <= {DATA_BITS{1'b0}};
    end
  end

  // Registered ack/error pulses, high for the single RESP cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      if_ack_r  <= 1'b0;
      dm_ack_r  <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      if_ack_r  <= (complete_s || timeout_s) && (last_grant_r == GRANT_IF);
      dm_ack_r  <= (complete_s || timeout_s) && (last_grant_r == GRANT_DM);
      bus_err_r <= timeout_s;
    end
  end

  assign if_ack     = if_ack_r;
  assign dm_ack     = dm_ack_r;
  assign if_rdata   = rdata_q_r[INSTR_BITS-1:0];
  assign dm_rdata   = rdata_q_r;
  assign bus_err    = bus_err_r;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_funct3 = mem_funct3_r;
  assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed requests, a behavioural memory
// with programmable latency, and a scoreboard of expected acks (port, data,
// error flag and arrival cycle) checked by an independent monitor.

module tb_mem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [IW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [2:0]    dm_funct3;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          bus_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_funct3;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  typedef struct {
    bit          is_dm;
    logic [63:0] data;
    bit          err;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // memory model controls: mode 0 = auto with latency, 1 = never ready, 2 = always ready
  int          mem_mode  = 0;
  int          mem_delay = 0;
  logic [63:0] mem_data_cfg = 64'h0;

  mem_port_arbiter #(
    .ADDR_BITS(AW), .DATA_BITS(DW), .INSTR_BITS(IW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_funct3(dm_funct3),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_funct3(mem_funct3),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: drives mem_ready/mem_rdata just after each rising edge
  initial begin
    int wait_cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 64'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_mode == 1) begin
        mem_ready = 1'b0;
      end else if (mem_mode == 2) begin
        mem_ready = 1'b1;
      end else if (mem_req && !reset) begin
        if (wait_cnt >= mem_delay) begin
          mem_ready = 1'b1;
          wait_cnt  = 0;
        end else begin
          mem_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end
      mem_rdata = mem_data_cfg;
    end
  end

  // Monitor: every ack pops one expectation and is compared against it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_ack === 1'b1 || dm_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got if_ack=%0b dm_ack=%0b expected no ack (cycle %0d)",
                   if_ack, dm_ack, cyc);
        end else begin
          e = exp_q.pop_front();
          check("ack_port", {62'd0, if_ack, dm_ack}, e.is_dm ? 64'd1 : 64'd2);
          if (e.is_dm) check("dm_rdata", dm_rdata, e.data);
          else         check("if_rdata", {32'd0, if_rdata}, {32'd0, e.data[31:0]});
          check("bus_err", {63'd0, bus_err}, {63'd0, e.err});
          check("ack_cycle", cyc, e.at);
        end
      end
    end
  end

  task automatic push_exp(bit is_dm, logic [63:0] data, bit err, int at);
    exp_t e;
    e.is_dm = is_dm; e.data = data; e.err = err; e.at = at;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for the ack of one port, then drops that request
  task automatic wait_ack(bit dm, int budget, string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dm ? dm_ack : if_ack) && n < budget);
    if (!(dm ? dm_ack : if_ack)) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no ack expected ack within %0d cycles", name, budget);
    end
    if (dm) dm_req = 1'b0;
    else    if_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation hung");
  end

  initial begin
    int c;
    bit ok;
    int acks;
    reset = 1'b1;
    if_req = 1'b0; if_addr = 64'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 64'h0; dm_funct3 = 3'd0; dm_wdata = 64'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_ctrl", {59'd0, mem_req, mem_we, if_ack, dm_ack, bus_err}, 64'd0);
    check("rst_addr", mem_addr, 64'd0);
    check("rst_funct3_wdata", {61'd0, mem_funct3} | mem_wdata, 64'd0);
    check("rst_rdata", dm_rdata, 64'd0);

    // Single fetch, zero memory latency
    mem_mode = 0; mem_delay = 0; mem_data_cfg = 64'hFFFF_FFFF_0050_0093;
    if_addr = 64'h100; if_req = 1'b1;
    c = cyc;
    push_exp(1'b0, 64'h0000_0000_0050_0093, 1'b0, c + 2);
    @(negedge clk);
    check("fetch_mem_req", {63'd0, mem_req}, 64'd1);
    check("fetch_mem_addr", mem_addr, 64'h100);
    check("fetch_we_f3", {60'd0, mem_we, mem_funct3}, 64'd0);
    wait_ack(1'b0, 20, "fetch");
    repeat (2) @(negedge clk);

    // Store with 4 extra cycles of memory latency
    mem_delay = 4; mem_data_cfg = 64'h0123_4567_89AB_CDEF;
    dm_we = 1'b1; dm_addr = 64'h2000; dm_wdata = 64'hDEAD_BEEF; dm_funct3 = 3'd3; dm_req = 1'b1;
    c = cyc;
    push_exp(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, c + 6);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!(mem_req === 1'b1 && mem_we === 1'b1 && mem_addr === 64'h2000 &&
            mem_funct3 === 3'd3 && mem_wdata === 64'hDEAD_BEEF)) ok = 1'b0;
    end
    check("store_cmd_stable", {63'd0, ok}, 64'd1);
    wait_ack(1'b1, 20, "store");
    check("store_req_dropped", {63'd0, mem_req}, 64'd0);
    dm_we = 1'b0;
    repeat (2) @(negedge clk);

    // Contention after reset: DM first, then alternation while both held
    do_reset();
    @(negedge clk);
    mem_delay = 0; mem_data_cfg = 64'h1122_3344_5566_7788;
    if_addr = 64'h40; dm_addr = 64'h3000; dm_funct3 = 3'd2;
    if_req = 1'b1; dm_req = 1'b1;
    c = cyc;
    push_exp(1'b1, 64'h1122_3344_5566_7788, 1'b0, c + 2);
    push_exp(1'b0, 64'h0000_0000_5566_7788, 1'b0, c + 5);
    push_exp(1'b1, 64'h1122_3344_5566_7788, 1'b0, c + 8);
    push_exp(1'b0, 64'h0000_0000_5566_7788, 1'b0, c + 11);
    @(negedge clk);
    check("contend_first_addr", mem_addr, 64'h3000);
    acks = 0;
    for (int n = 0; n < 40 && acks < 4; n++) begin
      @(negedge clk);
      if (if_ack || dm_ack) acks++;
    end
    check("contend_ack_count", acks, 64'd4);
    if_req = 1'b0; dm_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while BUSY: no ack, late mem_ready ignored, then a clean fetch
    mem_mode = 1;
    dm_addr = 64'h4000; dm_req = 1'b1;
    c = cyc;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; dm_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy_mem_req", {63'd0, mem_req}, 64'd0);
    mem_mode = 2;
    repeat (2) @(negedge clk);
    check("late_ready_ignored", {62'd0, mem_req, if_ack | dm_ack}, 64'd0);
    mem_mode = 0; mem_delay = 1; mem_data_cfg = 64'h0000_0000_1234_5678;
    if_addr = 64'h200; if_req = 1'b1;
    c = cyc;
    push_exp(1'b0, 64'h0000_0000_1234_5678, 1'b0, c + 3);
    wait_ack(1'b0, 20, "post_reset_fetch");
    repeat (2) @(negedge clk);

    // Ready in the 8th BUSY cycle: normal completion, no error
    mem_delay = 7; mem_data_cfg = 64'hCAFE_F00D_0000_0042;
    dm_addr = 64'h5000; dm_req = 1'b1;
    c = cyc;
    push_exp(1'b1, 64'hCAFE_F00D_0000_0042, 1'b0, c + 9);
    wait_ack(1'b1, 20, "limit_tie");
    repeat (2) @(negedge clk);

    // Memory never ready
    mem_mode = 1; mem_data_cfg = 64'hAAAA_AAAA_AAAA_AAAA;
    dm_addr = 64'h6000; dm_req = 1'b1;
    c = cyc;
`ifdef ARB_TIMEOUT_EN
    push_exp(1'b1, 64'h0, 1'b1, c + 9);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_req !== 1'b1) ok = 1'b0;
    end
    check("timeout_busy_window", {63'd0, ok}, 64'd1);
    wait_ack(1'b1, 20, "timeout");
    check("timeout_req_dropped", {63'd0, mem_req}, 64'd0);
    mem_mode = 0;
`else
    ok = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (mem_req !== 1'b1) ok = 1'b0;
    end
    check("no_watchdog_hold", {63'd0, ok}, 64'd1);
    mem_mode = 0;
    do_reset();
`endif
    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
